contador_param: RTL and testbench

- Parametrised synchronous up/down/step/load counter built as a cascade of STAGE_W-bit stages.
- Successor to the fixed 32-bit, 4-bit-slice counter:
  - width and stage size are parameters;
  - carry/borrow ripples combinationally, so all stages update on the same clock edge;
  - adds a saturating wrap-event counter.
- Used as a timer/event counter in the microelectronics project datapath.

---
 rtl/contador_param_pkg.sv | 17 +
 rtl/contador_etapa.sv | 28 ++
 rtl/contador_param.sv | 93 +++++++++
 tb/tb_contador_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/contador_param_pkg.sv
// Shared definitions for the cascaded counter: mode encoding and step constants.
package contador_param_pkg;

    localparam logic [1:0] MODE_UP1  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP3  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] STEP_ONE   = 2'd1;
    localparam logic [1:0] STEP_THREE = 2'd3;

    // Down mode also injects 1, as a borrow rather than a carry.
    function automatic logic [1:0] step_of(input logic [1:0] mode);
        return (mode == MODE_UP3) ? STEP_THREE : STEP_ONE;
    endfunction

endpackage

// File: rtl/contador_etapa.sv
// One combinational counter stage: next value and carry/borrow out from current value and carry in.
module contador_etapa #(
    parameter int STAGE_W = 4
) (
    input  logic [STAGE_W-1:0] val_i,
    input  logic [1:0]         carry_i,
    input  logic               down_i,
    output logic [STAGE_W-1:0] next_o,
    output logic               carry_o
);

    logic [STAGE_W:0] sum;
    logic [STAGE_W:0] diff;

    // One extra bit holds carry (up) or borrow (down); STAGE_W >= 2 keeps a +3 carry-out to one bit.
    always_comb begin
        sum  = {1'b0, val_i} + {{(STAGE_W-1){1'b0}}, carry_i};
        diff = {1'b0, val_i} - {{(STAGE_W-1){1'b0}}, carry_i};
        if (down_i) begin
            next_o  = diff[STAGE_W-1:0];
            carry_o = diff[STAGE_W];
        end else begin
            next_o  = sum[STAGE_W-1:0];
            carry_o = sum[STAGE_W];
        end
    end

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down/step-3/load counter built from a ripple cascade of STAGE_W-bit stages,
// with a registered wrap pulse and a saturating wrap-event counter.
module contador_param
    import contador_param_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             load,
    output logic             rco,
    output logic [CNT_W-1:0] wrap_cnt
);

    localparam int NSTG = WIDTH / STAGE_W;

    logic [WIDTH-1:0]       q_q, q_d;
    logic                   load_q, load_d;
    logic                   rco_q, rco_d;
    logic [CNT_W-1:0]       wc_q, wc_d;

    logic [WIDTH-1:0]       cnt_next;
    logic [NSTG-1:0][1:0]   carry;
    logic [NSTG-1:0]        stage_co;
    logic                   down;
    logic                   wrap;

    assign down = (mode == MODE_DN1);
    assign wrap = stage_co[NSTG-1];

    always_comb begin
        carry[0] = step_of(mode);
        for (int k = 1; k < NSTG; k++) begin
            carry[k] = {1'b0, stage_co[k-1]};
        end
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        contador_etapa #(.STAGE_W(STAGE_W)) u_etapa (
            .val_i   (q_q[g*STAGE_W +: STAGE_W]),
            .carry_i (carry[g]),
            .down_i  (down),
            .next_o  (cnt_next[g*STAGE_W +: STAGE_W]),
            .carry_o (stage_co[g])
        );
    end

    always_comb begin
        q_d    = q_q;
        load_d = 1'b0;
        rco_d  = 1'b0;
        wc_d   = wc_q;
        if (enable) begin
            if (mode == MODE_LOAD) begin
                q_d    = D;
                load_d = 1'b1;
                wc_d   = '0;
            end else begin
                q_d   = cnt_next;
                rco_d = wrap;
                if (wrap && (wc_q != {CNT_W{1'b1}})) begin
                    wc_d = wc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            load_q <= 1'b0;
            rco_q  <= 1'b0;
            wc_q   <= '0;
        end else begin
            q_q    <= q_d;
            load_q <= load_d;
            rco_q  <= rco_d;
            wc_q   <= wc_d;
        end
    end

    assign Q        = q_q;
    assign load     = load_q;
    assign rco      = rco_q;
    assign wrap_cnt = wc_q;

endmodule

// File: tb/tb_contador_param.sv
// Randomised and directed bench for contador_param: a 32-bit/CNT_W=8 instance and an 8-bit/CNT_W=2 instance.
module tb_contador_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_en = 1'b0;
    logic [1:0]  a_mode = 2'b00;
    logic [31:0] a_d = '0;
    logic [31:0] a_q;
    logic        a_load, a_rco;
    logic [7:0]  a_wc;

    logic        b_en = 1'b0;
    logic [1:0]  b_mode = 2'b00;
    logic [7:0]  b_d = '0;
    logic [7:0]  b_q;
    logic        b_load, b_rco;
    logic [1:0]  b_wc;

    logic [63:0] ma_q = '0, mb_q = '0;
    int          ma_wc = 0, mb_wc = 0;
    logic        ma_ld = 1'b0, ma_rc = 1'b0, mb_ld = 1'b0, mb_rc = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(32), .STAGE_W(4), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .enable(a_en), .mode(a_mode), .D(a_d),
        .Q(a_q), .load(a_load), .rco(a_rco), .wrap_cnt(a_wc)
    );

    contador_param #(.WIDTH(8), .STAGE_W(4), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .enable(b_en), .mode(b_mode), .D(b_d),
        .Q(b_q), .load(b_load), .rco(b_rco), .wrap_cnt(b_wc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic reference: counter value taken modulo 2^w, wrap from the true sum/difference.
    task automatic mstep(input int w, input int cw, input logic en, input logic [1:0] md,
                         input logic [63:0] d, inout logic [63:0] q, inout int wc,
                         output logic ld, output logic rc);
        logic [63:0] modv, s;
        modv = 64'd1 << w;
        ld = 1'b0;
        rc = 1'b0;
        if (en) begin
            if (md == 2'b11) begin
                q  = d % modv;
                ld = 1'b1;
                wc = 0;
            end else if (md == 2'b01) begin
                rc = (q == 0);
                q  = (q + modv - 1) % modv;
            end else begin
                s  = q + ((md == 2'b10) ? 64'd3 : 64'd1);
                rc = (s >= modv);
                q  = s % modv;
            end
            if (rc && wc < (1 << cw) - 1) wc++;
        end
    endtask

    task automatic compare_all();
        chk("a_q",    {32'b0, a_q},   ma_q);
        chk("a_load", {63'b0, a_load}, {63'b0, ma_ld});
        chk("a_rco",  {63'b0, a_rco},  {63'b0, ma_rc});
        chk("a_wc",   {56'b0, a_wc},   64'(ma_wc));
        chk("b_q",    {56'b0, b_q},    mb_q);
        chk("b_load", {63'b0, b_load}, {63'b0, mb_ld});
        chk("b_rco",  {63'b0, b_rco},  {63'b0, mb_rc});
        chk("b_wc",   {62'b0, b_wc},   64'(mb_wc));
    endtask

    task automatic model_reset();
        ma_q = '0; ma_wc = 0; ma_ld = 1'b0; ma_rc = 1'b0;
        mb_q = '0; mb_wc = 0; mb_ld = 1'b0; mb_rc = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mstep(32, 8, a_en, a_mode, {32'b0, a_d}, ma_q, ma_wc, ma_ld, ma_rc);
        mstep(8, 2, b_en, b_mode, {56'b0, b_d}, mb_q, mb_wc, mb_ld, mb_rc);
        compare_all();
    endtask

    task automatic drive_a(input logic en, input logic [1:0] md, input logic [31:0] d);
        a_en = en; a_mode = md; a_d = d;
    endtask

    task automatic drive_b(input logic en, input logic [1:0] md, input logic [7:0] d);
        b_en = en; b_mode = md; b_d = d;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Reset mid-count discards the in-flight load pulse immediately.
        drive_a(1'b1, 2'b11, 32'h0000_1234);
        tick();
        chk("pre_rst_q", {32'b0, a_q}, 64'h1234);
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_q", {32'b0, a_q}, 64'h0);
        chk("rst_load", {63'b0, a_load}, 64'h0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2 reset = 1'b0;
        drive_a(1'b1, 2'b00, 32'h0);
        tick();
        chk("rst_first", {32'b0, a_q}, 64'h1);

        drive_a(1'b1, 2'b11, 32'hFFFF_FFFE);
        tick();
        chk("ld_q", {32'b0, a_q}, 64'hFFFF_FFFE);
        chk("ld_pulse", {63'b0, a_load}, 64'h1);
        drive_a(1'b1, 2'b00, 32'h0);
        tick();
        chk("up_top_q", {32'b0, a_q}, 64'hFFFF_FFFF);
        chk("up_top_rco", {63'b0, a_rco}, 64'h0);
        tick();
        chk("up_wrap_q", {32'b0, a_q}, 64'h0);
        chk("up_wrap_rco", {63'b0, a_rco}, 64'h1);
        chk("up_wrap_wc", {56'b0, a_wc}, 64'h1);
        tick();
        chk("rco_drop", {63'b0, a_rco}, 64'h0);

        drive_a(1'b1, 2'b11, 32'hFFFF_FFFE);
        tick();
        drive_a(1'b1, 2'b10, 32'h0);
        tick();
        chk("up3_wrap_q", {32'b0, a_q}, 64'h1);
        chk("up3_wrap_rco", {63'b0, a_rco}, 64'h1);
        drive_a(1'b1, 2'b11, 32'h0000_000E);
        tick();
        drive_a(1'b1, 2'b10, 32'h0);
        tick();
        chk("up3_carry_q", {32'b0, a_q}, 64'h11);

        drive_a(1'b1, 2'b11, 32'h0001_0000);
        tick();
        drive_a(1'b1, 2'b01, 32'h0);
        tick();
        chk("dn_borrow_q", {32'b0, a_q}, 64'h0000_FFFF);
        chk("dn_borrow_rco", {63'b0, a_rco}, 64'h0);
        drive_a(1'b1, 2'b11, 32'h0);
        tick();
        drive_a(1'b1, 2'b01, 32'h0);
        tick();
        chk("dn_wrap_q", {32'b0, a_q}, 64'hFFFF_FFFF);
        chk("dn_wrap_rco", {63'b0, a_rco}, 64'h1);

        drive_a(1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", {32'b0, a_q}, 64'hFFFF_FFFF);
            chk("hold_rco", {63'b0, a_rco}, 64'h0);
        end

        // 8-bit instance: step-3 wrap at the top, then saturation of a 2-bit wrap counter.
        drive_b(1'b1, 2'b11, 8'hFD);
        tick();
        drive_b(1'b1, 2'b10, 8'h0);
        tick();
        chk("b_up3_q", {56'b0, b_q}, 64'h0);
        chk("b_up3_rco", {63'b0, b_rco}, 64'h1);
        repeat (450) tick();
        chk("b_sat_wc", {62'b0, b_wc}, 64'h3);
        drive_b(1'b1, 2'b11, 8'h10);
        tick();
        chk("b_ld_clr_wc", {62'b0, b_wc}, 64'h0);

        for (int i = 0; i < 10000; i++) begin
            a_en   = ($urandom_range(0, 7) != 0);
            a_mode = 2'($urandom_range(0, 3));
            a_d    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5))
                                                 : 32'($urandom);
            b_en   = ($urandom_range(0, 7) != 0);
            b_mode = 2'($urandom_range(0, 3));
            b_d    = 8'($urandom_range(0, 255));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
